// File: rtl/pulse_demodulator.sv
// pulse_demodulator
//
// Recovers 5-bit messages from a single-wire PWM or PPM slot-modulated line.
// A frame is 34 slots of SLOT_CYCLES clocks. The line is resynchronised,
// then sampled once per slot at the slot midpoint, and a small FSM decides
// the message value or flags a malformed frame.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   In     in   modulated serial line (asynchronous to clk)
//   Mode   in   0 = PWM, 1 = PPM; only looked at on the frame-start cycle
//   Msg    out  [4:0] last decoded message, changes only with Valid
//   Valid  out  one-cycle strobe, Msg updated on the same cycle
//   Err    out  one-cycle strobe for a malformed frame, Msg untouched
//   Busy   out  high while a frame is being decoded
//
// Handshake: Valid and Err are push-only strobes with no ready/back-pressure;
// each is high for exactly one cycle, they never coincide, and the consumer
// must capture Msg on the Valid cycle (it then holds until the next Valid).
module pulse_demodulator #(
  parameter int SLOT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       In,
  input  logic       Mode,
  output logic [4:0] Msg,
  output logic       Valid,
  output logic       Err,
  output logic       Busy
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(SLOT_CYCLES / 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PWM_HIGH = 2'd1,
    S_PPM_GAP  = 2'd2,
    S_PPM_DATA = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [1:0]      fill_q;
  logic            armed_q, armed_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      slot_q, slot_d;
  logic [4:0]      msg_q, msg_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            rise;
  logic            start;
  logic            sample_tick;
  logic            done_ok;
  logic            done_err;
  logic [4:0]      dec_msg;

  assign rise        = sync2_q & ~prev_q;
  assign start       = (state_q == S_IDLE) && armed_q && rise;
  assign sample_tick = (state_q != S_IDLE) && (cnt_q == CNT_MID);

  // Synchronizer, edge-detect history and a fill marker. The synchronizer
  // resets to 0, so its first two post-reset outputs are not real line
  // samples; fill_q keeps those from arming the receiver, which would
  // otherwise let a line held high through reset start a bogus frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  // State register plus the registered datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
      msg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      msg_q   <= msg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. Decisions are only taken on the mid-slot sample tick,
  // so line edges anywhere else in a slot have no effect.
  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_err = 1'b0;
    dec_msg  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = Mode ? S_PPM_GAP : S_PWM_HIGH;
      end
      S_PWM_HIGH: begin
        if (sample_tick) begin
          if (!sync2_q) begin
            // A low slot 0 would mean the pulse vanished before its first
            // sample: no valid width, treat as malformed.
            if (slot_q == 6'd0) begin
              done_err = 1'b1;
            end else begin
              done_ok = 1'b1;
              dec_msg = 5'(slot_q - 6'd1);
            end
          end else if (slot_q == 6'd32) begin
            done_err = 1'b1;
          end
        end
      end
      S_PPM_GAP: begin
        // Slot 0 holds the sync pulse and is not checked.
        if (sample_tick && (slot_q == 6'd1)) begin
          if (sync2_q) done_err = 1'b1;
          else         state_d  = S_PPM_DATA;
        end
      end
      S_PPM_DATA: begin
        if (sample_tick) begin
          if (sync2_q) begin
            done_ok = 1'b1;
            dec_msg = 5'(slot_q - 6'd2);
          end else if (slot_q == 6'd33) begin
            done_err = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_ok || done_err) state_d = S_IDLE;
  end

  // Output / datapath logic. The counter is 1 on the cycle after the start
  // cycle, so the start cycle itself counts as cycle 0 of slot 0 and slot k
  // is sampled SLOT_CYCLES/2 cycles into it, counted from the start cycle.
  always_comb begin
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    msg_d   = msg_q;
    valid_d = done_ok;
    err_d   = done_err;
    armed_d = armed_q;

    if (start) begin
      cnt_d  = CW'(1);
      slot_d = '0;
    end else if (done_ok || done_err) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        slot_d = slot_q + 6'd1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end

    if (done_ok) msg_d = dec_msg;

    // Re-arming needs a genuine low sample while idle, so a line that is
    // still high after a frame ends cannot start another one.
    if (done_ok || done_err) begin
      armed_d = 1'b0;
    end else if ((state_q == S_IDLE) && fill_q[1] && !sync2_q) begin
      armed_d = 1'b1;
    end
  end

  assign Msg   = msg_q;
  assign Valid = valid_q;
  assign Err   = err_q;
  assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_demodulator.sv
module tb_pulse_demodulator;

  localparam int SC = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       In    = 1'b0;
  logic       Mode  = 1'b0;
  logic [4:0] Msg;
  logic       Valid;
  logic       Err;
  logic       Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_n = 0, err_n = 0, valid_at = 0, err_at = 0;
  int rise_cyc = 0, v0 = 0, e0 = 0;

  logic [4:0] exp_q[$];

  pulse_demodulator #(.SLOT_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .In    (In),
    .Mode  (Mode),
    .Msg   (Msg),
    .Valid (Valid),
    .Err   (Err),
    .Busy  (Busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (Valid) begin
        valid_n  <= valid_n + 1;
        valid_at <= cyc;
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else                   check("sb_msg", {27'd0, Msg}, {27'd0, exp_q.pop_front()});
      end
      if (Err) begin
        err_n  <= err_n + 1;
        err_at <= cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [39:0] pwm_pat(input int m);
    return (40'd1 << (m + 1)) - 40'd1;
  endfunction

  function automatic logic [39:0] ppm_pat(input int m);
    return 40'd1 | (40'd1 << (m + 2));
  endfunction

  // Bit s of pat is the line level for slot s. Leaves In at the last level.
  task automatic send(input logic mode, input logic [39:0] pat, input int nslots);
    @(negedge clk);
    Mode     = mode;
    rise_cyc = cyc;
    v0       = valid_n;
    e0       = err_n;
    for (int s = 0; s < nslots; s++) begin
      In = pat[s];
      repeat (SC) @(negedge clk);
    end
  endtask

  task automatic idle_low(input int n);
    In = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Latency is measured from the cycle In was driven high; the synchronizer
  // adds 2 cycles ahead of the frame-start cycle.
  task automatic expect_frame(input string name, input logic is_err,
                              input int exp_lat, input logic [4:0] exp_msg);
    check($sformatf("%s_valid_cnt", name), valid_n - v0, is_err ? 0 : 1);
    check($sformatf("%s_err_cnt", name), err_n - e0, is_err ? 1 : 0);
    check($sformatf("%s_latency", name), (is_err ? err_at : valid_at) - rise_cyc, exp_lat);
    check($sformatf("%s_msg", name), {27'd0, Msg}, {27'd0, exp_msg});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_msg",   {27'd0, Msg}, 0);
    check("rst_valid", Valid, 0);
    check("rst_err",   Err, 0);
    check("rst_busy",  Busy, 0);
    rst_n = 1'b1;
    idle_low(6);

    // PWM m=23: Valid at E+393
    exp_q.push_back(5'd23);
    send(1'b0, pwm_pat(23), 34);
    idle_low(4);
    expect_frame("pwm23", 1'b0, 395, 5'd23);

    // PPM m=0: Valid at E+41
    exp_q.push_back(5'd0);
    send(1'b1, ppm_pat(0), 34);
    idle_low(4);
    expect_frame("ppm0", 1'b0, 43, 5'd0);

    // PPM m=31 (data in slot 33): Valid at E+537, then back-to-back m=5
    exp_q.push_back(5'd31);
    send(1'b1, ppm_pat(31), 34);
    idle_low(4);
    expect_frame("ppm31", 1'b0, 539, 5'd31);
    exp_q.push_back(5'd5);
    send(1'b1, ppm_pat(5), 34);
    idle_low(4);
    expect_frame("ppm5", 1'b0, 123, 5'd5);

    // PWM held high for 40 slots: Err at E+521, no retrigger while high
    send(1'b0, 40'hFF_FFFF_FFFF, 40);
    expect_frame("pwm_long", 1'b1, 523, 5'd5);
    repeat (64) @(negedge clk);
    check("pwm_long_no_retrig_busy", Busy, 0);
    check("pwm_long_no_retrig_err", err_n - e0, 1);
    idle_low(4);

    // PPM without data pulse: Err at E+537
    send(1'b1, 40'h1, 34);
    idle_low(4);
    expect_frame("ppm_nodata", 1'b1, 539, 5'd5);

    // PPM high in slot 1: Err at E+25
    send(1'b1, 40'h3, 34);
    idle_low(4);
    expect_frame("ppm_slot1", 1'b1, 27, 5'd5);

    // Reset at slot 10 of a PWM frame
    @(negedge clk);
    Mode = 1'b0;
    In   = 1'b1;
    repeat (SC * 10) @(negedge clk);
    check("mid_busy", Busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_msg",   {27'd0, Msg}, 0);
    check("mid_rst_valid", Valid, 0);
    check("mid_rst_err",   Err, 0);
    check("mid_rst_busy",  Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_n;
    e0 = err_n;
    repeat (SC * 40) @(negedge clk);
    check("held_high_busy", Busy, 0);
    check("held_high_events", (valid_n - v0) + (err_n - e0), 0);
    idle_low(4);
    exp_q.push_back(5'd9);
    send(1'b0, pwm_pat(9), 34);
    idle_low(4);
    expect_frame("pwm9", 1'b0, 171, 5'd9);

    // Mode flipped to PPM at slot 5 of a PWM m=12 frame: still PWM
    exp_q.push_back(5'd12);
    fork
      send(1'b0, pwm_pat(12), 34);
      begin
        repeat (SC * 5 + 3) @(negedge clk);
        Mode = 1'b1;
      end
    join
    idle_low(4);
    Mode = 1'b0;
    expect_frame("mode_tog", 1'b0, 219, 5'd12);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_demodulator.md
# pulse_demodulator

Receive-side counterpart of the modulator top level: recovers 5-bit messages from a single-wire PWM or PPM slot-modulated stream and presents each one with a one-cycle valid strobe. It sits at the receiving end of the modulated link, driven by the same system clock. It uses its own slot-timing counter and mid-slot sampling in place of the transmitter's frequency divider.

## Interface

- SLOT_CYCLES, 16, clock cycles per modulation slot; even, ≥ 4
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- In  input  1  modulated serial line, asynchronous to clk
- Mode  input  1  0 = PWM, 1 = PPM; captured at frame start
- Msg  output  5  last decoded message; holds until the next Valid
- Valid  output  1  one-cycle strobe, Msg updated on the same cycle
- Err  output  1  one-cycle strobe on a malformed frame; Msg is unchanged
- Busy  output  1  high while a frame is being decoded

## Operation

- **Line format:** frame = 34 slots of SLOT_CYCLES cycles, message value m in 0..31.
  - PWM: line high for m+1 slots from frame start, then low.
  - PPM: one-slot sync pulse in slot 0, low in slot 1, one-slot data pulse in slot m+2, low elsewhere.
- **Input path:** In passes through a 2-flop synchronizer. A registered previous sample provides edge detection.
- **Armed flag:**
  - Set by any synchronized low sample while in IDLE.
  - Cleared by reset and by every frame end (Valid or Err).
  - A frame starts only on a synchronized rising edge while armed.
- **Frame start (cycle E):** the first cycle the synchronized sample is 1 and the previous sample was 0. At E: cyc_cnt ← 0, slot ← 0, Mode latched, Busy ← 1.
- **Slot timing:**
  - cyc_cnt increments each cycle and wraps at SLOT_CYCLES−1; slot increments on the wrap.
  - The line is sampled when cyc_cnt == SLOT_CYCLES/2, so slot k is sampled at E + k·SLOT_CYCLES + SLOT_CYCLES/2.
- **States:** IDLE, PWM_HIGH, PPM_GAP, PPM_DATA.
  - IDLE → PWM_HIGH or PPM_GAP at E, according to latched Mode.
  - PWM_HIGH: first low sample at slot k → Msg ← k−1, Valid, back to IDLE. High sample at slot 32 → Err, IDLE.
  - PPM_GAP: slot 0 sample ignored. Slot 1 sample low → PPM_DATA. Slot 1 sample high → Err, IDLE.
  - PPM_DATA: first high sample at slot s (2..33) → Msg ← s−2, Valid, IDLE. Slot 33 sampled low → Err, IDLE.
- **Width rule:** k−1 and s−2 are computed in 6 bits; the result is always in 0..31, so truncation to 5 bits is exact.
- **Simultaneous events:**
  - Mode changes during a frame are ignored.
  - Line edges outside sample points are ignored.
  - After Valid or Err, a new frame needs a low sample first; a line still high cannot retrigger.
- **Reset:**
  - Asynchronous, active low; reset mid-frame aborts the frame with no Valid and no Err.
  - Reset values: Msg = 0, Valid = 0, Err = 0, Busy = 0, state IDLE, armed = 0, counters 0, synchronizer flops 0.

## Timing

- Raw rising edge of In to E: 2 clk cycles through the synchronizer, plus up to 1 cycle of sampling uncertainty.
- Valid and Err assert on the cycle after the deciding sample: E + k·SLOT_CYCLES + SLOT_CYCLES/2 + 1. Busy falls on that same cycle.
- Valid and Err last exactly one cycle and are mutually exclusive.
- Msg is registered and changes only on the Valid cycle.
- Throughput: one frame per 34 slots. The receiver is ready for the next rising edge 1 cycle after Valid or Err, provided a low sample has been seen.

## Test plan

All scenarios use SLOT_CYCLES = 16.

1. PWM, Mode = 0, m = 23 (5'b10111): In high for 24 slots then low → Valid at E+393, Msg = 5'b10111, Err never asserted.
2. PPM, Mode = 1, m = 0: sync pulse in slot 0, data pulse in slot 2 → Valid at E+41, Msg = 0.
3. PPM, m = 31, data pulse in slot 33 → Valid at E+537, Msg = 31. A back-to-back second frame with m = 5 → Msg = 5.
4. Errors, each with Msg unchanged:
   - PWM line held high for 40 slots → Err at E+521, no Valid; no new frame until In goes low and rises again.
   - PPM with no data pulse → Err at E+537.
   - PPM high in slot 1 → Err at E+25.
5. Reset mid-frame: assert rst_n low at slot 10 of a PWM frame → Msg, Valid, Err and Busy are 0 immediately. Release with In still high → no frame. In low then high → normal decode.
6. Mode toggled from 0 to 1 at slot 5 of a PWM frame with m = 12 → decoded as PWM: Valid at E+217, Msg = 12.
